// File: rtl/delay_vec_sequencer.sv
// -----------------------------------------------------------------------------
// delay_vec_sequencer
// Steps a fixed table of {A,B,C} vectors into a 3-input delay gate, waits a
// settle window per vector, samples the synchronised gate output Y and compares
// it against the expected table. Reports a pass/fail verdict, mismatch count
// and the index of the first mismatching vector for each run.
//
// Ports
//   clk          in   rising-edge system clock
//   rst_n        in   asynchronous active-low reset
//   i_start      in   1-cycle pulse, begins a run when idle
//   i_abort      in   synchronous run abort, no done pulse
//   i_y          in   gate output, asynchronous to clk
//   o_a/o_b/o_c  out  registered gate inputs
//   o_busy       out  run in progress
//   o_done       out  1-cycle pulse at the end of a completed run
//   o_pass       out  run verdict, valid from done until next start
//   o_fail_cnt   out  number of mismatching vectors
//   o_first_err  out  index of first mismatching vector, 4'hF if none
// -----------------------------------------------------------------------------
module delay_vec_sequencer #(
    parameter int unsigned          NUM_VEC    = 3,
    parameter logic [3*NUM_VEC-1:0] VEC_TABLE  = 9'b101_010_111,
    parameter logic [NUM_VEC-1:0]   EXP_Y      = 3'b101,
    parameter int unsigned          SETTLE_CYC = 4,
    parameter int unsigned          HOLD_CYC   = 8,
    localparam int unsigned         W          = $clog2(NUM_VEC + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic         i_y,
    output logic         o_a,
    output logic         o_b,
    output logic         o_c,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_pass,
    output logic [W-1:0] o_fail_cnt,
    output logic [3:0]   o_first_err
);

    // Counter must reach HOLD_CYC-1 without wrapping.
    localparam int unsigned    CW        = $clog2(HOLD_CYC + 1);
    localparam logic [CW-1:0]  SAMPLE_AT = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0]  HOLD_END  = CW'(HOLD_CYC - 1);
    localparam logic [3:0]     LAST_IDX  = 4'(NUM_VEC - 1);

    // Illegal parameter sets stop elaboration rather than producing a sequencer
    // whose sample point precedes the synchroniser latency.
    if ((SETTLE_CYC < 3) || (HOLD_CYC <= SETTLE_CYC) || (NUM_VEC > 16) || (NUM_VEC < 1)) begin : g_param_check
        $fatal(1, "delay_vec_sequencer: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SAMPLE = 3'd2,
        S_HOLD   = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t               r_state;
    logic [3:0]           r_idx;
    logic [CW-1:0]        r_cnt;
    logic                 r_y_meta;
    logic                 r_y_sync;

    logic [3:0]           w_idx_inc;
    logic [3*NUM_VEC-1:0] w_vec_shift;
    logic [2:0]           w_vec_next;
    logic [NUM_VEC-1:0]   w_exp_shift;
    logic                 w_exp_bit;
    logic                 w_mismatch;

    assign w_idx_inc   = r_idx + 4'd1;
    assign w_vec_shift = VEC_TABLE >> ({28'd0, w_idx_inc} * 32'd3);
    assign w_vec_next  = w_vec_shift[2:0];
    assign w_exp_shift = EXP_Y >> r_idx;
    assign w_exp_bit   = w_exp_shift[0];
    assign w_mismatch  = (r_y_sync != w_exp_bit);

    // Two-flop synchroniser for the asynchronous gate output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_meta <= 1'b0;
            r_y_sync <= 1'b0;
        end else begin
            r_y_meta <= i_y;
            r_y_sync <= r_y_meta;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= 4'd0;
            r_cnt       <= {CW{1'b0}};
            o_a         <= 1'b0;
            o_b         <= 1'b0;
            o_c         <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_fail_cnt  <= {W{1'b0}};
            o_first_err <= 4'hF;
        end else if (i_abort && (r_state != S_IDLE)) begin
            // Abort keeps the partial counters; pass is already 0 mid-run.
            r_state           <= S_IDLE;
            {o_a, o_b, o_c}   <= 3'b000;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    {o_a, o_b, o_c} <= 3'b000;
                    o_done          <= 1'b0;
                    // abort in the same cycle suppresses the start
                    if (i_start && !i_abort) begin
                        r_state         <= S_DRIVE;
                        r_idx           <= 4'd0;
                        r_cnt           <= {CW{1'b0}};
                        {o_a, o_b, o_c} <= VEC_TABLE[2:0];
                        o_busy          <= 1'b1;
                        o_pass          <= 1'b0;
                        o_fail_cnt      <= {W{1'b0}};
                        o_first_err     <= 4'hF;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRIVE: begin
                    r_cnt <= r_cnt + CW'(1'b1);
                    if (r_cnt == SAMPLE_AT) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_state <= S_DRIVE;
                    end
                end
                S_SAMPLE: begin
                    r_cnt <= r_cnt + CW'(1'b1);
                    if (w_mismatch) begin
                        o_fail_cnt <= o_fail_cnt + W'(1'b1);
                        if (o_first_err == 4'hF) begin
                            o_first_err <= r_idx;
                        end else begin
                            o_first_err <= o_first_err;
                        end
                    end else begin
                        o_fail_cnt <= o_fail_cnt;
                    end
                    // SETTLE_CYC+1 == HOLD_CYC skips HOLD entirely
                    if (r_cnt == HOLD_END) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_END) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1'b1);
                        r_state <= S_HOLD;
                    end
                end
                S_NEXT: begin
                    if (r_idx == LAST_IDX) begin
                        r_state         <= S_DONE;
                        {o_a, o_b, o_c} <= 3'b000;
                        o_busy          <= 1'b0;
                        o_done          <= 1'b1;
                        o_pass          <= (o_fail_cnt == {W{1'b0}});
                    end else begin
                        r_state         <= S_DRIVE;
                        r_idx           <= w_idx_inc;
                        r_cnt           <= {CW{1'b0}};
                        {o_a, o_b, o_c} <= w_vec_next;
                    end
                end
                S_DONE: begin
                    // start arriving here is deliberately not honoured
                    r_state <= S_IDLE;
                    o_done  <= 1'b0;
                end
                default: begin
                    r_state         <= S_IDLE;
                    {o_a, o_b, o_c} <= 3'b000;
                    o_busy          <= 1'b0;
                    o_done          <= 1'b0;
                end
            endcase
        end
    end

endmodule
